// File: rtl/serial_add_ctrl_if.sv
// Command/result bundle between a requester and the bit-serial add/subtract sequencer.
// The requester drives the operands and start; the sequencer returns status and the result.
interface serial_add_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit add/subtract sequencer: one full-adder cell stepped LSB-first,
// one bit per clock, with the carry held in a register between steps.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_PEN  = CW'(W - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  sum_r;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          msb_cin;
    logic          cout_r;
    logic          ovf_r;

    logic fa_s;
    logic fa_c;

    // The single full-adder cell; B already holds ~b for subtract, carry was seeded with sub.
    assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c = (a_sr[0] & b_sr[0]) | ((a_sr[0] | b_sr[0]) & carry);

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_r   <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= bus.b ^ {W{bus.sub}};
                        carry   <= bus.sub;
                        cnt     <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                        msb_cin <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r <= {fa_s, sum_r[W-1:1]};
                    a_sr  <= {1'b0, a_sr[W-1:1]};
                    b_sr  <= {1'b0, b_sr[W-1:1]};
                    carry <= fa_c;
                    // Carry out of bit W-2 is the carry into the MSB, needed for signed overflow.
                    if (cnt == CNT_PEN) begin
                        msb_cin <= fa_c;
                    end
                    if (cnt == CNT_LAST) begin
                        cout_r <= fa_c;
                        ovf_r  <= msb_cin ^ fa_c;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance for the directed cases and
// a 4-bit instance swept over every operand pair in both modes.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int passes = 0;

    serial_add_ctrl_if #(.W(8)) bus8 ();
    serial_add_ctrl_if #(.W(4)) bus4 ();

    serial_add_ctrl #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_add_ctrl #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the 8-bit instance, wait a bounded time for done, capture
    // results in the done cycle and step into the following IDLE cycle.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           output logic got, output int lat, output int busy_n,
                           output logic [7:0] s, output logic co, output logic ov);
        bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        got = 1'b0; lat = 0; busy_n = 0;
        s = 'x; co = 1'bx; ov = 1'bx;
        while (!got && lat < 20) begin
            if (bus8.done) begin
                got = 1'b1;
                s = bus8.sum; co = bus8.cout; ov = bus8.ovf;
            end else begin
                if (bus8.busy) busy_n++;
                tick();
                lat++;
            end
        end
        tick();
    endtask

    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                           output logic got, output int lat,
                           output logic [3:0] s, output logic co, output logic ov);
        bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        got = 1'b0; lat = 0;
        s = 'x; co = 1'bx; ov = 1'bx;
        while (!got && lat < 12) begin
            if (bus4.done) begin
                got = 1'b1;
                s = bus4.sum; co = bus4.cout; ov = bus4.ovf;
            end else begin
                tick();
                lat++;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b0;
        bus4.start = 1'b1; bus4.a = 4'h3;  bus4.b = 4'h4;  bus4.sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bus8.start = 1'b0;
        bus4.start = 1'b0;
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 11'd0)
            $display("FAIL reset8: busy/done/sum/cout/ovf = %b, expected all zero",
                     {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf});
        else passes++;
        checks++;
        if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf} !== 7'd0)
            $display("FAIL reset4: busy/done/sum/cout/ovf = %b, expected all zero",
                     {bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf});
        else passes++;
        tick();
        checks++;
        if (bus8.busy !== 1'b0)
            $display("FAIL reset_start_dominated: busy = %b, expected 0", bus8.busy);
        else passes++;
    endtask

    task automatic test_basic();
        logic got; int lat; int busy_n; logic [7:0] s; logic co; logic ov;
        run_op8(8'h3C, 8'h5A, 1'b0, got, lat, busy_n, s, co, ov);
        checks++;
        if (!got) $display("FAIL basic_done: no done within 20 cycles, expected done");
        else passes++;
        checks++;
        if (lat !== 8) $display("FAIL basic_latency: got %0d cycles, expected 8", lat);
        else passes++;
        checks++;
        if (busy_n !== 8) $display("FAIL basic_busy: busy high %0d cycles, expected 8", busy_n);
        else passes++;
        checks++;
        if ({s, co, ov} !== {8'h96, 1'b0, 1'b1})
            $display("FAIL basic_result: sum=%h cout=%b ovf=%b, expected sum=96 cout=0 ovf=1",
                     s, co, ov);
        else passes++;
        tick(); tick(); tick();
        checks++;
        if ({bus8.sum, bus8.cout, bus8.ovf, bus8.busy, bus8.done} !== {8'h96, 1'b0, 1'b1, 1'b0, 1'b0})
            $display("FAIL basic_hold: sum=%h cout=%b ovf=%b busy=%b done=%b, expected 96/0/1/0/0",
                     bus8.sum, bus8.cout, bus8.ovf, bus8.busy, bus8.done);
        else passes++;
    endtask

    task automatic test_arith();
        logic [7:0] va [6] = '{8'hFF, 8'h00, 8'h05, 8'h80, 8'h7F, 8'h00};
        logic [7:0] vb [6] = '{8'h01, 8'h00, 8'h07, 8'h01, 8'h01, 8'h00};
        logic       vs [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [7:0] es [6] = '{8'h00, 8'h00, 8'hFE, 8'h7F, 8'h80, 8'h00};
        logic       ec [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        logic       eo [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            logic got; int lat; int busy_n; logic [7:0] s; logic co; logic ov;
            run_op8(va[i], vb[i], vs[i], got, lat, busy_n, s, co, ov);
            checks++;
            if (!got || {s, co, ov} !== {es[i], ec[i], eo[i]})
                $display("FAIL arith[%0d]: done=%b sum=%h cout=%b ovf=%b, expected done=1 sum=%h cout=%b ovf=%b",
                         i, got, s, co, ov, es[i], ec[i], eo[i]);
            else passes++;
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic post_busy = 1'b1;
        logic prev_done = 1'b0;
        logic [7:0] s = 'x; logic co = 1'bx; logic ov = 1'bx;
        bus8.a = 8'h11; bus8.b = 8'h22; bus8.sub = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.sub = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (prev_done) post_busy = bus8.busy;
            prev_done = bus8.done;
            if (bus8.done) begin
                dones++;
                s = bus8.sum; co = bus8.cout; ov = bus8.ovf;
            end
            bus8.start = (k == 3) || bus8.done;
            tick();
        end
        bus8.start = 1'b0;
        checks++;
        if (dones !== 1) $display("FAIL ignore_dones: %0d done pulses, expected 1", dones);
        else passes++;
        checks++;
        if ({s, co, ov} !== {8'h33, 1'b0, 1'b0})
            $display("FAIL ignore_result: sum=%h cout=%b ovf=%b, expected sum=33 cout=0 ovf=0", s, co, ov);
        else passes++;
        checks++;
        if (post_busy !== 1'b0)
            $display("FAIL ignore_done_start: busy=%b after done, expected 0", post_busy);
        else passes++;
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        logic got; int lat; int busy_n; logic [7:0] s; logic co; logic ov;
        bus8.a = 8'h55; bus8.b = 8'h0F; bus8.sub = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        bus8.start = 1'b1;
        tick();
        rst = 1'b0;
        bus8.start = 1'b0;
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 11'd0)
            $display("FAIL midrst_outputs: busy/done/sum/cout/ovf = %b, expected all zero",
                     {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf});
        else passes++;
        for (int k = 0; k < 12; k++) begin
            if (bus8.done || bus8.busy) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) $display("FAIL midrst_abort: %0d busy/done cycles after reset, expected 0", dones);
        else passes++;
        run_op8(8'h12, 8'h34, 1'b0, got, lat, busy_n, s, co, ov);
        checks++;
        if (!got || {s, co, ov} !== {8'h46, 1'b0, 1'b0})
            $display("FAIL midrst_restart: done=%b sum=%h cout=%b ovf=%b, expected done=1 sum=46 cout=0 ovf=0",
                     got, s, co, ov);
        else passes++;
    endtask

    task automatic test_sweep4();
        int errs = 0;
        for (int sb = 0; sb < 2; sb++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    logic got; int lat; logic [3:0] s; logic co; logic ov;
                    int sa, sbv, r;
                    logic [3:0] es; logic ec; logic eo;
                    sa  = (ia >= 8) ? ia - 16 : ia;
                    sbv = (ib >= 8) ? ib - 16 : ib;
                    r   = (sb != 0) ? sa - sbv : sa + sbv;
                    es  = (sb != 0) ? 4'(ia - ib) : 4'(ia + ib);
                    ec  = (sb != 0) ? (ia >= ib) : (ia + ib > 15);
                    eo  = (r > 7) || (r < -8);
                    run_op4(4'(ia), 4'(ib), sb[0], got, lat, s, co, ov);
                    checks++;
                    if (!got || lat != 4 || {s, co, ov} !== {es, ec, eo}) begin
                        errs++;
                        if (errs <= 10)
                            $display("FAIL sweep4 a=%h b=%h sub=%0d: done=%b lat=%0d sum=%h cout=%b ovf=%b, expected lat=4 sum=%h cout=%b ovf=%b",
                                     ia, ib, sb, got, lat, s, co, ov, es, ec, eo);
                    end else passes++;
                end
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
        #1;
        test_reset();
        test_basic();
        test_arith();
        test_ignore_start();
        test_reset_mid_run();
        test_sweep4();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
